heap_alloc_arbiter: RTL and testbench
=====================================

# heap_alloc_arbiter

Owns the single port of the heap RAM (12-bit address, 8-bit data) and shares it between two requesters: the evaluator, which issues single-word reads, and the cons allocator path, which builds a new cons cell. Allocation is a bump-pointer FSM that writes a 5-word cell (header, car pointer, cdr pointer) as one atomic burst. Arbitration is round-robin at transaction granularity. The block sits between the evaluator FSM and the heap RAM.

## Interface
Parameters:
- `HEAP_BASE`, default 12'h010: first allocatable address. Addresses below it are reserved, so NIL (0) is never returned as a live cell.
- `HEAP_LIMIT`, default 12'hFFF: last allocatable address, inclusive.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rd_req`  in  1  evaluator read request; held with `rd_addr` until `rd_valid`.
- `rd_addr`  in  12  evaluator read address.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid in this cycle.
- `rd_data`  out  8  read data (`mem_rdata` pass-through).
- `alloc_req`  in  1  cons allocation request; held with operands until `alloc_done`.
- `alloc_car`  in  12  car pointer.
- `alloc_cdr`  in  12  cdr pointer.
- `alloc_done`  out  1  one-cycle pulse; `alloc_ptr` is valid in this cycle.
- `alloc_ptr`  out  12  address of the new cell, or NIL on out-of-memory. Held until the next `alloc_done`.
- `alloc_oom`  out  1  sticky out-of-memory flag.
- `mem_addr`  out  12  RAM address.
- `mem_wdata`  out  8  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_rdata`  in  8  RAM read data; the RAM is synchronous with 1-cycle read latency.

## Operation
- Cell layout at pointer P:
  - P+0 = header TYPE_CONS (8'h01)
  - P+1 = {4'h0, car[11:8]}
  - P+2 = car[7:0]
  - P+3 = {4'h0, cdr[11:8]}
  - P+4 = cdr[7:0]
- State `free_ptr` (12 bits) resets to `HEAP_BASE`. `last_win` (1 bit) resets to READ.
- FSM states: Idle, Read, ReadWait, Write, Done.
  - Idle, no request pending: stay in Idle.
  - Idle, only `rd_req`: go to Read.
  - Idle, only `alloc_req`: go to Write, or to Done on OOM.
  - Idle, both pending: grant the class that did not win last (`last_win != READ` grants the read), then update `last_win`.
  - Read: drive `mem_addr = rd_addr`, `mem_we = 0`, then go to ReadWait.
  - ReadWait: `rd_valid = 1`, then go to Idle.
  - Write: a 3-bit counter k runs 0..4. Drive `mem_addr = free_ptr + k`, `mem_we = 1`, `mem_wdata` = layout word k. After k = 4, go to Done.
  - Done: `alloc_done = 1`, `alloc_ptr = free_ptr`, `free_ptr += 5`, then go to Idle.
- `alloc_car` and `alloc_cdr` are latched on acceptance. Changes to the inputs afterwards are ignored.
- OOM check happens at acceptance. OOM condition: `free_ptr + 5 > HEAP_LIMIT + 1`, computed in 13 bits, so there is no wrap-around.
- On OOM: skip Write entirely (no `mem_we`) and go to Done with `alloc_ptr = NIL`. Set `alloc_oom`; `free_ptr` is unchanged.
- Once `alloc_oom` is set, every later allocation takes the OOM path. `alloc_oom` clears only on reset.
- Outside Read and Write: `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- Reset values:
  - `rd_valid`, `alloc_done`, `alloc_oom`, `mem_we` = 0
  - `alloc_ptr` = NIL
  - `mem_addr`, `mem_wdata` = 0
  - FSM = Idle
- Reset mid-burst: `mem_we` drops asynchronously and the partial cell is abandoned. `free_ptr` returns to `HEAP_BASE`, so the next allocation overwrites it.

## Timing
- Requests are sampled at the edge that leaves Idle. Call the cycle after that edge cycle 1.
- Read: address on RAM in cycle 1, `rd_valid` in cycle 2, Idle in cycle 3. Occupancy is 3 cycles including Idle.
- Alloc: `mem_we` high in cycles 1–5, `alloc_done` in cycle 6, Idle in cycle 7.
- OOM alloc: `alloc_done` in cycle 1, with `alloc_oom` already high in that cycle.
- A write burst is never interrupted. A read arriving mid-burst waits for Idle.
- Maximum wait for either requester is one transaction of the other class.

## Configuration
- `HEAP_ALLOC_STATS_EN`
  - Defined: adds output port `alloc_count[15:0]`. Reset value 0. Increments in every non-OOM Done cycle and saturates at 16'hFFFF.
  - Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Alloc after reset, car=12'h123, cdr=NIL -> writes 0x010=01, 0x011=01, 0x012=23, 0x013=00, 0x014=00 in cycles 1–5; `alloc_done` in cycle 6 with ptr 0x010. A second alloc returns 0x015.
- Read of 0x012 after the first test -> `rd_valid` 2 cycles after acceptance with `rd_data` = 8'h23; `mem_we` stays 0 throughout.
- `rd_req` and `alloc_req` both asserted in the first Idle after reset -> alloc wins (`last_win` = READ) and the read completes right after. Repeat both asserted again -> this time the read is served first.
- `HEAP_LIMIT` = 12'h019, three allocs -> ptrs 0x010 and 0x015, then NIL with `alloc_oom` = 1 and no `mem_we`. A fourth alloc also returns NIL.
- Assert `rst` during write k = 2 -> `mem_we` = 0 immediately. The next alloc returns 0x010 and rewrites all 5 words.
- With `HEAP_ALLOC_STATS_EN` defined and `HEAP_LIMIT` = 12'h019, three allocs -> `alloc_count` = 2 (OOM not counted).

Source files
------------

// File: rtl/heap_alloc_arbiter.sv
// Single-port heap RAM arbiter: round-robin between evaluator reads and atomic 5-word cons writes.
// Optional HEAP_ALLOC_STATS_EN adds o_alloc_count (saturating count of successful allocations).
module heap_alloc_arbiter #(
   parameter logic [11:0] HEAP_BASE  = 12'h010,
   parameter logic [11:0] HEAP_LIMIT = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rd_req,
   input  logic [11:0] i_rd_addr,
   output logic        o_rd_valid,
   output logic [7:0]  o_rd_data,
   input  logic        i_alloc_req,
   input  logic [11:0] i_alloc_car,
   input  logic [11:0] i_alloc_cdr,
   output logic        o_alloc_done,
   output logic [11:0] o_alloc_ptr,
   output logic        o_alloc_oom,
   output logic [11:0] o_mem_addr,
   output logic [7:0]  o_mem_wdata,
   output logic        o_mem_we,
`ifdef HEAP_ALLOC_STATS_EN
   output logic [15:0] o_alloc_count,
`endif
   input  logic [7:0]  i_mem_rdata
);

   localparam logic [11:0] NIL        = 12'h000;
   localparam logic        LAST_READ  = 1'b0;
   localparam logic        LAST_ALLOC = 1'b1;

   typedef enum logic [2:0] {StIdle, StRead, StReadWait, StWrite, StDone} state_e;

   state_e      r_state, w_state_nxt;
   // One extra bit so a cell ending exactly at 12'hFFF cannot wrap the pointer back to NIL.
   logic [12:0] r_free_ptr;
   logic [11:0] r_car, r_cdr, r_alloc_ptr;
   logic [2:0]  r_k;
   logic        r_last_win, r_oom;

   logic        w_grant_rd, w_grant_alloc, w_oom_now;
   logic [12:0] w_need, w_cap;
   logic [7:0]  w_word;
   logic [11:0] w_done_ptr;

   assign w_need     = r_free_ptr + 13'd5;
   assign w_cap      = {1'b0, HEAP_LIMIT} + 13'd1;
   assign w_oom_now  = r_oom || (w_need > w_cap);
   assign w_done_ptr = r_oom ? NIL : r_free_ptr[11:0];
   assign o_rd_data  = i_mem_rdata;
   assign o_alloc_oom = r_oom;

   always_comb begin
      w_grant_rd    = 1'b0;
      w_grant_alloc = 1'b0;
      if (r_state == StIdle) begin
         if (i_rd_req && i_alloc_req) begin
            if (r_last_win == LAST_READ) w_grant_alloc = 1'b1;
            else                         w_grant_rd    = 1'b1;
         end else if (i_rd_req) begin
            w_grant_rd = 1'b1;
         end else if (i_alloc_req) begin
            w_grant_alloc = 1'b1;
         end
      end
   end

   always_comb begin
      case (r_k)
         3'd0:    w_word = 8'h01;
         3'd1:    w_word = {4'h0, r_car[11:8]};
         3'd2:    w_word = r_car[7:0];
         3'd3:    w_word = {4'h0, r_cdr[11:8]};
         default: w_word = r_cdr[7:0];
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_rd_valid   = 1'b0;
      o_alloc_done = 1'b0;
      o_alloc_ptr  = r_alloc_ptr;
      o_mem_addr   = 12'h000;
      o_mem_wdata  = 8'h00;
      o_mem_we     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_grant_rd)         w_state_nxt = StRead;
            else if (w_grant_alloc) w_state_nxt = w_oom_now ? StDone : StWrite;
         end
         StRead: begin
            o_mem_addr  = i_rd_addr;
            w_state_nxt = StReadWait;
         end
         StReadWait: begin
            o_rd_valid  = 1'b1;
            w_state_nxt = StIdle;
         end
         StWrite: begin
            o_mem_addr  = r_free_ptr[11:0] + {9'b0, r_k};
            o_mem_wdata = w_word;
            o_mem_we    = 1'b1;
            if (r_k == 3'd4) w_state_nxt = StDone;
         end
         StDone: begin
            o_alloc_done = 1'b1;
            o_alloc_ptr  = w_done_ptr;
            w_state_nxt  = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_free_ptr  <= {1'b0, HEAP_BASE};
         r_last_win  <= LAST_READ;
         r_oom       <= 1'b0;
         r_k         <= 3'd0;
         r_car       <= 12'h000;
         r_cdr       <= 12'h000;
         r_alloc_ptr <= NIL;
      end else begin
         r_state <= w_state_nxt;
         // Fairness pointer only moves when both classes actually contended.
         if (r_state == StIdle && i_rd_req && i_alloc_req) begin
            r_last_win <= w_grant_rd ? LAST_READ : LAST_ALLOC;
         end
         if (w_grant_alloc) begin
            r_car <= i_alloc_car;
            r_cdr <= i_alloc_cdr;
            r_k   <= 3'd0;
            if (w_oom_now) r_oom <= 1'b1;
         end
         if (r_state == StWrite) r_k <= r_k + 3'd1;
         if (r_state == StDone) begin
            r_alloc_ptr <= w_done_ptr;
            if (!r_oom) r_free_ptr <= r_free_ptr + 13'd5;
         end
      end
   end

`ifdef HEAP_ALLOC_STATS_EN
   logic [15:0] r_alloc_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alloc_count <= 16'h0000;
      end else if (r_state == StDone && !r_oom && r_alloc_count != 16'hFFFF) begin
         r_alloc_count <= r_alloc_count + 16'd1;
      end
   end

   assign o_alloc_count = r_alloc_count;
`endif

endmodule

// File: tb/tb_heap_alloc_arbiter.sv
// Directed bench: instance 0 uses the default heap, instance 1 a tiny heap (limit 0x019) for OOM.
module tb_heap_alloc_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req    [2];
   logic [11:0] rd_addr   [2];
   logic        rd_valid  [2];
   logic [7:0]  rd_data   [2];
   logic        alloc_req [2];
   logic [11:0] alloc_car [2];
   logic [11:0] alloc_cdr [2];
   logic        alloc_done[2];
   logic [11:0] alloc_ptr [2];
   logic        alloc_oom [2];
   logic [11:0] mem_addr  [2];
   logic [7:0]  mem_wdata [2];
   logic        mem_we    [2];
   logic [7:0]  mem_rdata [2];
`ifdef HEAP_ALLOC_STATS_EN
   logic [15:0] alloc_count[2];
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [7:0] ram [4096];

      heap_alloc_arbiter #(
         .HEAP_BASE  (12'h010),
         .HEAP_LIMIT ((g == 0) ? 12'hFFF : 12'h019)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .i_rd_req     (rd_req[g]),
         .i_rd_addr    (rd_addr[g]),
         .o_rd_valid   (rd_valid[g]),
         .o_rd_data    (rd_data[g]),
         .i_alloc_req  (alloc_req[g]),
         .i_alloc_car  (alloc_car[g]),
         .i_alloc_cdr  (alloc_cdr[g]),
         .o_alloc_done (alloc_done[g]),
         .o_alloc_ptr  (alloc_ptr[g]),
         .o_alloc_oom  (alloc_oom[g]),
         .o_mem_addr   (mem_addr[g]),
         .o_mem_wdata  (mem_wdata[g]),
         .o_mem_we     (mem_we[g]),
`ifdef HEAP_ALLOC_STATS_EN
         .o_alloc_count(alloc_count[g]),
`endif
         .i_mem_rdata  (mem_rdata[g])
      );

      always @(posedge clk) begin
         if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
         mem_rdata[g] <= ram[mem_addr[g]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] cell_word(input int k, input logic [11:0] car,
                                             input logic [11:0] cdr);
      case (k)
         0:       return 8'h01;
         1:       return {4'h0, car[11:8]};
         2:       return car[7:0];
         3:       return {4'h0, cdr[11:8]};
         default: return cdr[7:0];
      endcase
   endfunction

   task automatic start_alloc(input int d, input logic [11:0] car, input logic [11:0] cdr);
      @(negedge clk);
      alloc_req[d] = 1'b1;
      alloc_car[d] = car;
      alloc_cdr[d] = cdr;
   endtask

   // Called right after the accepting edge; ends in the Done cycle with the request dropped.
   task automatic alloc_body(input int d, input logic [11:0] car, input logic [11:0] cdr,
                             input logic [11:0] exp_ptr, input logic exp_oom);
      if (!exp_oom) begin
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("burst_we", mem_we[d], 1);
            check("burst_addr", mem_addr[d], exp_ptr + k);
            check("burst_wdata", mem_wdata[d], cell_word(k, car, cdr));
            check("burst_no_done", alloc_done[d], 0);
            check("burst_no_rd_valid", rd_valid[d], 0);
         end
      end
      @(negedge clk);
      check("done_pulse", alloc_done[d], 1);
      check("done_ptr", alloc_ptr[d], exp_oom ? 12'h000 : exp_ptr);
      check("done_oom", alloc_oom[d], exp_oom);
      check("done_we_low", mem_we[d], 0);
      alloc_req[d] = 1'b0;
   endtask

   // Called right after the accepting edge; ends in the ReadWait cycle with the request dropped.
   task automatic read_body(input int d, input logic [11:0] addr, input logic [7:0] exp);
      @(negedge clk);
      check("read_addr", mem_addr[d], addr);
      check("read_we_low", mem_we[d], 0);
      check("read_not_yet_valid", rd_valid[d], 0);
      @(negedge clk);
      check("read_valid", rd_valid[d], 1);
      check("read_data", rd_data[d], exp);
      check("read_wait_we_low", mem_we[d], 0);
      rd_req[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rd_req[i]    = 1'b0;
         rd_addr[i]   = 12'h000;
         alloc_req[i] = 1'b0;
         alloc_car[i] = 12'h000;
         alloc_cdr[i] = 12'h000;
      end
      repeat (2) @(negedge clk);
      check("rst_rd_valid", rd_valid[0], 0);
      check("rst_alloc_done", alloc_done[0], 0);
      check("rst_alloc_oom", alloc_oom[0], 0);
      check("rst_mem_we", mem_we[0], 0);
      check("rst_alloc_ptr", alloc_ptr[0], 12'h000);
      check("rst_mem_addr", mem_addr[0], 12'h000);
      check("rst_mem_wdata", mem_wdata[0], 8'h00);
      rst = 1'b0;

      // First contention after reset: alloc wins, read follows.
      @(negedge clk);
      rd_req[0]  = 1'b1;
      rd_addr[0] = 12'h012;
      start_alloc_now(0, 12'h123, 12'h000);
      alloc_body(0, 12'h123, 12'h000, 12'h010, 1'b0);
      @(negedge clk);
      check("rd_still_waiting", rd_valid[0], 0);
      check("idle_we_low", mem_we[0], 0);
      read_body(0, 12'h012, 8'h23);

      // Second contention: read goes first this time.
      @(negedge clk);
      rd_req[0]  = 1'b1;
      rd_addr[0] = 12'h011;
      start_alloc_now(0, 12'hABC, 12'h5DE);
      read_body(0, 12'h011, 8'h01);
      @(negedge clk);
      check("alloc_waiting", alloc_done[0], 0);
      check("ptr_held", alloc_ptr[0], 12'h010);
      alloc_body(0, 12'hABC, 12'h5DE, 12'h015, 1'b0);

      // Standalone read of the second cell's car low byte.
      @(negedge clk);
      rd_req[0]  = 1'b1;
      rd_addr[0] = 12'h017;
      read_body(0, 12'h017, 8'hBC);

      // Tiny heap: two cells fit exactly, then OOM.
      start_alloc(1, 12'h001, 12'h002);
      alloc_body(1, 12'h001, 12'h002, 12'h010, 1'b0);
      start_alloc(1, 12'h003, 12'h004);
      alloc_body(1, 12'h003, 12'h004, 12'h015, 1'b0);
      @(negedge clk);
      check("small_ptr_held", alloc_ptr[1], 12'h015);
      check("small_not_oom", alloc_oom[1], 0);
      start_alloc(1, 12'h005, 12'h006);
      alloc_body(1, 12'h005, 12'h006, 12'h000, 1'b1);
      start_alloc(1, 12'h007, 12'h008);
      alloc_body(1, 12'h007, 12'h008, 12'h000, 1'b1);
`ifdef HEAP_ALLOC_STATS_EN
      @(negedge clk);
      check("alloc_count", alloc_count[1], 16'd2);
`endif

      // Reset at burst word k=2.
      start_alloc(0, 12'h777, 12'h888);
      repeat (3) @(negedge clk);
      check("midburst_we", mem_we[0], 1);
      check("midburst_addr", mem_addr[0], 12'h01C);
      #1 rst = 1'b1;
      #1;
      check("async_we_drop", mem_we[0], 0);
      check("async_addr_zero", mem_addr[0], 12'h000);
      check("async_oom_clear", alloc_oom[1], 0);
      alloc_req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      start_alloc(0, 12'h456, 12'h789);
      alloc_body(0, 12'h456, 12'h789, 12'h010, 1'b0);
      start_alloc(1, 12'h00A, 12'h00B);
      alloc_body(1, 12'h00A, 12'h00B, 12'h010, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Raises an alloc request in the current cycle without waiting for another negedge.
   task automatic start_alloc_now(input int d, input logic [11:0] car, input logic [11:0] cdr);
      alloc_req[d] = 1'b1;
      alloc_car[d] = car;
      alloc_cdr[d] = cdr;
   endtask

endmodule
